// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: redirect, decode dequeue and instruction SRAM signals of the fetch queue
interface inst_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_num;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [63:0] inst_sram_rdata;
  logic        deq_valid1;
  logic        deq_valid2;
  logic [31:0] deq_inst1;
  logic [31:0] deq_inst2;
  logic [31:0] deq_pc1;
  logic [31:0] deq_pc2;
  modport master (
    input  redirect, redirect_pc, deq_num, inst_sram_rdata,
    output inst_sram_en, inst_sram_addr, deq_valid1, deq_valid2,
           deq_inst1, deq_inst2, deq_pc1, deq_pc2
  );
  modport slave (
    output redirect, redirect_pc, deq_num, inst_sram_rdata,
    input  inst_sram_en, inst_sram_addr, deq_valid1, deq_valid2,
           deq_inst1, deq_inst2, deq_pc1, deq_pc2
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC sequencer, 64-bit SRAM unpacking and dual-output instruction queue
module inst_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   pc_fetch;
  logic [31:0]   resp_pc;
  logic          resp_v;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [1:0]    resp_words;
  logic          req;
  logic          enq;
  assign resp_words = resp_v ? (resp_pc[2] ? 2'd1 : 2'd2) : 2'd0;
  assign req = !rst && ((CW+1)'(count) + (CW+1)'(resp_words) <= (CW+1)'(DEPTH - 2));
  assign enq = !rst && !bus.redirect && resp_v;
  // control state: fetch PC, outstanding response tracking, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_fetch <= RESET_PC;
      resp_v   <= 1'b0;
      resp_pc  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      pc_fetch <= bus.redirect_pc & ~32'd3;
      resp_v   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (req) pc_fetch <= pc_fetch + (pc_fetch[2] ? 32'd4 : 32'd8);
      resp_v  <= req;
      resp_pc <= pc_fetch;
      tail    <= tail + AW'(resp_words);
      head    <= head + AW'(bus.deq_num);
      count   <= count + CW'(resp_words) - CW'(bus.deq_num);
    end
  end
  // queue storage: the upper word belongs to the lower address, so an odd-word response keeps only rdata[31:0]
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= resp_pc[2] ? bus.inst_sram_rdata[31:0] : bus.inst_sram_rdata[63:32];
      q_pc[tail]   <= resp_pc;
      if (!resp_pc[2]) begin
        q_inst[tail + AW'(1)] <= bus.inst_sram_rdata[31:0];
        q_pc[tail + AW'(1)]   <= resp_pc + 32'd4;
      end
    end
  end
  assign bus.inst_sram_en   = req;
  assign bus.inst_sram_addr = rst ? '0 : {pc_fetch[31:3], 3'b000};
  assign bus.deq_valid1     = !rst && count != '0;
  assign bus.deq_valid2     = !rst && count > CW'(1);
  assign bus.deq_inst1      = bus.deq_valid1 ? q_inst[head] : '0;
  assign bus.deq_pc1        = bus.deq_valid1 ? q_pc[head] : '0;
  assign bus.deq_inst2      = bus.deq_valid2 ? q_inst[head + AW'(1)] : '0;
  assign bus.deq_pc2        = bus.deq_valid2 ? q_pc[head + AW'(1)] : '0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of streaming, redirect, back-pressure, wrap and reset
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  inst_fetch_queue_if bus();
  inst_fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction
  // SRAM model: one-cycle read latency, garbage when idle
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? {w(bus.inst_sram_addr), w(bus.inst_sram_addr + 32'd4)} : 64'hDEAD_BEEF_DEAD_BEEF;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, bus.inst_sram_en, 0);
    chk({tag, "_addr"}, bus.inst_sram_addr, 0);
    chk({tag, "_v1"}, bus.deq_valid1, 0);
    chk({tag, "_v2"}, bus.deq_valid2, 0);
    chk({tag, "_inst1"}, bus.deq_inst1, 0);
    chk({tag, "_pc1"}, bus.deq_pc1, 0);
    chk({tag, "_inst2"}, bus.deq_inst2, 0);
    chk({tag, "_pc2"}, bus.deq_pc2, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_num = 2'd0;
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("rst");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.deq_num = k >= 2 ? 2'd2 : 2'd0;
      @(negedge clk);
      chk("stream_en", bus.inst_sram_en, 1);
      chk("stream_addr", bus.inst_sram_addr, 32'hBFC0_0000 + 32'(8 * k));
      chk("stream_v1", bus.deq_valid1, k >= 2);
      chk("stream_v2", bus.deq_valid2, k >= 2);
      if (k >= 2) begin
        chk("stream_pc1", bus.deq_pc1, 32'hBFC0_0000 + 32'(8 * (k - 2)));
        chk("stream_pc2", bus.deq_pc2, 32'hBFC0_0004 + 32'(8 * (k - 2)));
        chk("stream_inst1", bus.deq_inst1, w(32'hBFC0_0000 + 32'(8 * (k - 2))));
        chk("stream_inst2", bus.deq_inst2, w(32'hBFC0_0004 + 32'(8 * (k - 2))));
      end
      if (k == 2) begin
        chk("first_inst1", bus.deq_inst1, 32'hE59A_A5A5);
        chk("first_inst2", bus.deq_inst2, 32'hE59A_A5A1);
      end
      tick();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h8000_0107;
    bus.deq_num = 2'd2;
    tick();
    bus.redirect = 1'b0;
    bus.deq_num = 2'd0;
    @(negedge clk);
    chk("redir_r1_addr", bus.inst_sram_addr, 32'h8000_0100);
    chk("redir_r1_en", bus.inst_sram_en, 1);
    chk("redir_r1_v1", bus.deq_valid1, 0);
    tick();
    @(negedge clk);
    chk("redir_r2_addr", bus.inst_sram_addr, 32'h8000_0108);
    chk("redir_r2_v1", bus.deq_valid1, 0);
    tick();
    bus.deq_num = 2'd1;
    @(negedge clk);
    chk("redir_r3_v1", bus.deq_valid1, 1);
    chk("redir_r3_pc1", bus.deq_pc1, 32'h8000_0104);
    chk("redir_r3_inst1", bus.deq_inst1, 32'hDA5A_A4A1);
    chk("redir_r3_v2", bus.deq_valid2, 0);
    chk("redir_r3_pc2", bus.deq_pc2, 0);
    tick();
    bus.deq_num = 2'd0;
    @(negedge clk);
    chk("redir_r4_v2", bus.deq_valid2, 1);
    chk("redir_r4_pc1", bus.deq_pc1, 32'h8000_0108);
    chk("redir_r4_pc2", bus.deq_pc2, 32'h8000_010C);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_1000;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.deq_num = i == 8 ? 2'd2 : 2'd0;
      @(negedge clk);
      chk("fill_en", bus.inst_sram_en, i <= 3 || i == 9);
      chk("fill_cnt_max", dut.count <= 8, 1);
      if (i == 6) begin
        chk("fill_count", dut.count, 8);
        chk("fill_pc1", bus.deq_pc1, 32'h0000_1000);
        chk("fill_inst2", bus.deq_inst2, 32'h5A5A_B5A1);
      end
      if (i == 9) chk("fill_resume_addr", bus.inst_sram_addr, 32'h0000_1020);
      tick();
    end
    bus.deq_num = 2'd0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    @(negedge clk);
    chk("full_redir_en", bus.inst_sram_en, 0);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("full_redir_count", dut.count, 0);
    chk("full_redir_v1", bus.deq_valid1, 0);
    chk("full_redir_v2", bus.deq_valid2, 0);
    chk("full_redir_addr", bus.inst_sram_addr, 32'h0000_2000);
    chk("full_redir_en2", bus.inst_sram_en, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("stale_r1_addr", bus.inst_sram_addr, 32'h0000_3000);
    chk("stale_r1_v1", bus.deq_valid1, 0);
    tick();
    @(negedge clk);
    chk("stale_r2_v1", bus.deq_valid1, 0);
    tick();
    @(negedge clk);
    chk("stale_r3_pc1", bus.deq_pc1, 32'h0000_3000);
    chk("stale_r3_pc2", bus.deq_pc2, 32'h0000_3004);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_4000;
    tick();
    bus.redirect = 1'b0;
    exp_pc = 32'h0000_4000;
    for (int j = 0; j < 19; j++) begin
      bus.deq_num = j < 2 ? 2'd0 : (j % 2 == 0 ? 2'd1 : 2'd2);
      @(negedge clk);
      if (j == 7 || j == 11) chk("wrap_stall", bus.inst_sram_en, 0);
      if (j == 8) chk("wrap_resume", bus.inst_sram_en, 1);
      if (j >= 2) begin
        chk("wrap_v1", bus.deq_valid1, 1);
        chk("wrap_v2", bus.deq_valid2, 1);
        chk("wrap_pc1", bus.deq_pc1, exp_pc);
        chk("wrap_pc2", bus.deq_pc2, exp_pc + 32'd4);
        chk("wrap_inst1", bus.deq_inst1, w(exp_pc));
        chk("wrap_inst2", bus.deq_inst2, w(exp_pc + 32'd4));
        exp_pc = exp_pc + 32'(bus.deq_num) * 32'd4;
      end
      tick();
    end
    bus.deq_num = 2'd0;
    @(negedge clk);
    chk("mid_pre_count", dut.count, 5);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_count", dut.count, 0);
    chk("mid_v1", bus.deq_valid1, 0);
    chk("mid_en", bus.inst_sram_en, 1);
    chk("mid_addr", bus.inst_sram_addr, 32'hBFC0_0000);
    tick();
    @(negedge clk);
    chk("mid_addr2", bus.inst_sram_addr, 32'hBFC0_0008);
    chk("mid_v1b", bus.deq_valid1, 0);
    tick();
    @(negedge clk);
    chk("mid_pc1", bus.deq_pc1, 32'hBFC0_0000);
    chk("mid_inst1", bus.deq_inst1, 32'hE59A_A5A5);
    chk("mid_pc2", bus.deq_pc2, 32'hBFC0_0004);
    chk("mid_inst2", bus.deq_inst2, 32'hE59A_A5A1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
